// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants for the 4-digit seven-segment driver:
//               hex font (active-low, dp bit set), counter widths, the
//               blank pin pattern and an anode-decode helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 2;
  localparam int PAGES   = 8;
  localparam int PAGE_W  = 3;
  localparam int ANODE_W = 4;
  localparam int SEG_W   = 7;
  localparam int PIN_W   = 12;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [PAGE_W-1:0]  page_t;

  // All anodes and cathodes high: every digit dark.
  localparam logic [PIN_W-1:0] BLANK = 12'hFFF;

  // Font byte {dp,g,f,e,d,c,b,a}, active-low; entry n sits at bits [8n+7:8n].
  localparam logic [15:0][7:0] FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // One-hot-low anode vector for digit position k.
  function automatic logic [ANODE_W-1:0] anode_for(input digit_t k);
    logic [ANODE_W-1:0] an;
    an    = '1;
    an[k] = 1'b0;
    return an;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg
// Description : Combinational hex-digit to seven-segment decoder.
// Ports       : nibble [3:0] in  - hex value to show
//               seg    [6:0] out - active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  // An X/Z nibble deliberately yields X segments rather than a guessed glyph.
  assign seg = FONT[nibble][SEG_W-1:0];

endmodule
`default_nettype wire

// File: rtl/seven_seg_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_driver
// Description : Time-multiplexed driver for a 4-digit common-anode display.
//               Shows a 128-bit word as 32 hex digits, four per page,
//               paging through eight pages automatically.
// Ports       : system1000       in   clock
//               system1000_rstn  in   asynchronous active-low reset
//               outputs_i1[127:0] in  value to display (nibble n = [4n+3:4n])
//               bodyVar_o[11:0]  out  registered pins: [11:8] anodes an3..an0,
//                                     [7:0] cathodes {dp,g..a}, all active-low
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 16384,
  parameter int unsigned PAGE_HOLD   = 256
) (
  input  logic               system1000,
  input  logic               system1000_rstn,
  input  logic [127:0]       outputs_i1,
  output logic [PIN_W-1:0]   bodyVar_o
);

  // Counters need at least one bit even when the divisor is 1.
  localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCAN_W = (PAGE_HOLD > 1)   ? $clog2(PAGE_HOLD)   : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(PAGE_HOLD - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  digit_t            digit;
  page_t             page;
  logic [PIN_W-1:0]  pins_q;

  logic [3:0]        nibble;
  logic [SEG_W-1:0]  seg;
  logic              dp_n;
  logic              tick_last;
  logic              scan_last;
  logic              digit_last;

  // Nibble index n = 4*page + digit, so the bit offset is {page,digit,2'b00}.
  assign nibble     = outputs_i1[{page, digit, 2'b00} +: 4];
  assign dp_n       = ~((page == '0) && (digit == '0));
  assign tick_last  = (tick_cnt == TICK_LAST);
  assign scan_last  = (scan_cnt == SCAN_LAST);
  assign digit_last = (digit == digit_t'(DIGITS - 1));

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (seg)
  );

  // Pins load from the counter values present at the edge, so the first
  // edge after reset shows page 0 / digit 0 while the counters move on.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      tick_cnt <= '0;
      scan_cnt <= '0;
      digit    <= '0;
      page     <= '0;
      pins_q   <= BLANK;
    end else begin
      pins_q <= {anode_for(digit), dp_n, seg};
      if (tick_last) begin
        tick_cnt <= '0;
        digit    <= digit + 2'd1;
        if (digit_last) begin
          if (scan_last) begin
            scan_cnt <= '0;
            page     <= page + 3'd1;
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
        end
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  assign bodyVar_o = pins_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_driver
// Description : Directed self-checking bench for seven_seg_driver. Four
//               instances with different REFRESH_DIV/PAGE_HOLD share clock,
//               reset and input word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_driver;

  logic         clk = 1'b0;
  logic         rstn;
  logic [127:0] data;
  logic [11:0]  out_a;   // REFRESH_DIV=2, PAGE_HOLD=1
  logic [11:0]  out_p;   // REFRESH_DIV=1, PAGE_HOLD=1
  logic [11:0]  out_h;   // REFRESH_DIV=1, PAGE_HOLD=3
  logic [11:0]  out_d;   // defaults

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] FONT_T [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  localparam logic [11:0] SCAN_EXP [9] = '{
    12'hE40, 12'hE40, 12'hDF9, 12'hDF9, 12'hBA4, 12'hBA4, 12'h7B0, 12'h7B0,
    12'hEC0
  };

  always #5 clk = ~clk;

  seven_seg_driver #(.REFRESH_DIV(2), .PAGE_HOLD(1)) dut_a (
    .system1000(clk), .system1000_rstn(rstn), .outputs_i1(data), .bodyVar_o(out_a));
  seven_seg_driver #(.REFRESH_DIV(1), .PAGE_HOLD(1)) dut_p (
    .system1000(clk), .system1000_rstn(rstn), .outputs_i1(data), .bodyVar_o(out_p));
  seven_seg_driver #(.REFRESH_DIV(1), .PAGE_HOLD(3)) dut_h (
    .system1000(clk), .system1000_rstn(rstn), .outputs_i1(data), .bodyVar_o(out_h));
  seven_seg_driver dut_d (
    .system1000(clk), .system1000_rstn(rstn), .outputs_i1(data), .bodyVar_o(out_d));

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(input int p, input int k, input logic [127:0] d);
    logic [3:0] nib;
    logic [3:0] an;
    logic [7:0] cat;
    nib   = d[(4*p + k)*4 +: 4];
    an    = 4'hF;
    an[k] = 1'b0;
    cat   = FONT_T[nib];
    if (p == 0 && k == 0) cat[7] = 1'b0;
    return {an, cat};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] prev;
    logic [11:0] exp;

    // Reset hold with clocks running
    rstn = 1'b0;
    data = '0;
    repeat (3) step();
    check("reset_a", out_a, 12'hFFF);
    check("reset_p", out_p, 12'hFFF);
    check("reset_h", out_h, 12'hFFF);
    check("reset_d", out_d, 12'hFFF);

    // Digit scan, REFRESH_DIV=2, then first digit of page 1
    data = 128'h3210;
    rstn = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      check($sformatf("scan_c%0d", c + 1), out_a, SCAN_EXP[c]);
    end

    // Paging and page hold over a full 8-page cycle plus wrap
    rstn = 1'b0;
    step();
    data = {64'h0, 64'hFEDCBA9876543210};
    rstn = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      step();
      check($sformatf("page_c%0d", c), out_p, model(((c - 1) / 4) % 8, (c - 1) % 4, data));
      check($sformatf("hold_c%0d", c), out_h, model(((c - 1) / 12) % 8, (c - 1) % 4, data));
    end

    // Asynchronous reset mid-count, no edge in between
    #2;
    rstn = 1'b0;
    #1;
    check("async_a", out_a, 12'hFFF);
    check("async_p", out_p, 12'hFFF);
    check("async_h", out_h, 12'hFFF);
    check("async_d", out_d, 12'hFFF);

    // Font sweep on digit 0 of page 0 (default divisor keeps k=0)
    data = '0;
    step();
    rstn = 1'b1;
    prev = 12'hFFF;
    for (int v = 0; v < 16; v++) begin
      data[3:0] = 4'(v);
      #1;
      check($sformatf("font_hold_%0d", v), out_d, prev);
      step();
      exp = {4'hE, 1'b0, FONT_T[v][6:0]};
      check($sformatf("font_%0d", v), out_d, exp);
      prev = exp;
    end

    // X input: anodes still scan cleanly
    rstn = 1'b0;
    step();
    data = 'x;
    rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      logic [3:0] an;
      an = 4'hF;
      an[c % 4] = 1'b0;
      step();
      check($sformatf("xan_c%0d", c + 1), {out_p[11:8], 8'h00}, {an, 8'h00});
    end

    rstn = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
